// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: resolves load-use, redirect and dmem-stall hazards into pipeline enables,
// runs the IDLE/RUN/MEM_WAIT state machine and keeps saturating performance counters.
module pipeline_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             clr_i,
  input  logic             idex_memread_i,
  input  logic [4:0]       idex_rt_i,
  input  logic [4:0]       ifid_rs_i,
  input  logic [4:0]       ifid_rt_i,
  input  logic             ifid_use_rt_i,
  input  logic             branch_taken_i,
  input  logic             jump_i,
  input  logic             dmem_stall_i,
  output logic             pc_we_o,
  output logic             ifid_we_o,
  output logic             ifid_flush_o,
  output logic             idex_bubble_o,
  output logic             pipe_stall_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] lu_cnt_o,
  output logic [CNT_W-1:0] fl_cnt_o,
  output logic [CNT_W-1:0] ms_cnt_o,
  output logic [CNT_W-1:0] miss_cnt_o
);
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, MEM_WAIT = 2'b10} state_t;
  state_t           r_state;
  logic [CNT_W-1:0] r_lu_cnt, r_fl_cnt, r_ms_cnt, r_miss_cnt;
  logic             w_active, w_go, w_lu, w_rd;
  assign w_active = r_state != IDLE;
  assign w_lu = idex_memread_i && idex_rt_i != 5'd0 &&
                (idex_rt_i == ifid_rs_i || (ifid_use_rt_i && idex_rt_i == ifid_rt_i));
  assign w_rd = branch_taken_i | jump_i;
  // a dmem stall freezes everything, so hazards are only acted on when w_go is set
  assign w_go = w_active & ~dmem_stall_i;
  assign pc_we_o       = w_go & ~w_lu;
  assign ifid_we_o     = w_go & ~w_lu;
  assign ifid_flush_o  = w_go & ~w_lu & w_rd;
  assign idex_bubble_o = w_go & w_lu;
  assign pipe_stall_o  = ~w_go;
  assign state_o    = r_state;
  assign lu_cnt_o   = r_lu_cnt;
  assign fl_cnt_o   = r_fl_cnt;
  assign ms_cnt_o   = r_ms_cnt;
  assign miss_cnt_o = r_miss_cnt;
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
    return (inc && !(&v)) ? v + CNT_W'(1) : v;
  endfunction
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= r_state == IDLE ? (start_i ? RUN : IDLE) :
                 dmem_stall_i    ? MEM_WAIT :
                 start_i         ? RUN : IDLE;
    end
  end
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_lu_cnt   <= '0;
      r_fl_cnt   <= '0;
      r_ms_cnt   <= '0;
      r_miss_cnt <= '0;
    end else if (clr_i) begin
      r_lu_cnt   <= '0;
      r_fl_cnt   <= '0;
      r_ms_cnt   <= '0;
      r_miss_cnt <= '0;
    end else begin
      r_lu_cnt   <= sat_inc(r_lu_cnt, idex_bubble_o);
      r_fl_cnt   <= sat_inc(r_fl_cnt, ifid_flush_o);
      r_ms_cnt   <= sat_inc(r_ms_cnt, w_active & dmem_stall_i);
      r_miss_cnt <= sat_inc(r_miss_cnt, r_state == RUN && dmem_stall_i);
    end
  end
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed checks of pipeline_ctrl with a 16-bit and a 2-bit counter instance
// sharing one stimulus stream.
module tb_pipeline_ctrl;
  logic clk, rst_n, start, clr, memread, use_rt, br, jmp, dmem;
  logic [4:0] ex_rt, id_rs, id_rt;
  logic pc_we, ifid_we, flush, bubble, stall;
  logic [1:0] st;
  logic [15:0] lu_cnt, fl_cnt, ms_cnt, miss_cnt;
  logic b_pc_we, b_ifid_we, b_flush, b_bubble, b_stall;
  logic [1:0] b_st;
  logic [1:0] b_lu, b_fl, b_ms, b_miss;
  int n_vec, n_err;
  int e_lu, e_fl, e_ms, e_miss;
  typedef struct {
    logic [4:0] en;
    logic [1:0] st;
    int lu, fl, ms, miss;
  } exp_t;
  exp_t sb[$];

  pipeline_ctrl #(.CNT_W(16)) dut (
    .clk_i(clk), .rst_i(rst_n), .start_i(start), .clr_i(clr),
    .idex_memread_i(memread), .idex_rt_i(ex_rt), .ifid_rs_i(id_rs), .ifid_rt_i(id_rt),
    .ifid_use_rt_i(use_rt), .branch_taken_i(br), .jump_i(jmp), .dmem_stall_i(dmem),
    .pc_we_o(pc_we), .ifid_we_o(ifid_we), .ifid_flush_o(flush), .idex_bubble_o(bubble),
    .pipe_stall_o(stall), .state_o(st), .lu_cnt_o(lu_cnt), .fl_cnt_o(fl_cnt),
    .ms_cnt_o(ms_cnt), .miss_cnt_o(miss_cnt));

  pipeline_ctrl #(.CNT_W(2)) dut_b (
    .clk_i(clk), .rst_i(rst_n), .start_i(start), .clr_i(clr),
    .idex_memread_i(memread), .idex_rt_i(ex_rt), .ifid_rs_i(id_rs), .ifid_rt_i(id_rt),
    .ifid_use_rt_i(use_rt), .branch_taken_i(br), .jump_i(jmp), .dmem_stall_i(dmem),
    .pc_we_o(b_pc_we), .ifid_we_o(b_ifid_we), .ifid_flush_o(b_flush), .idex_bubble_o(b_bubble),
    .pipe_stall_o(b_stall), .state_o(b_st), .lu_cnt_o(b_lu), .fl_cnt_o(b_fl),
    .ms_cnt_o(b_ms), .miss_cnt_o(b_miss));

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] sat3(input int v);
    return v > 3 ? 32'd3 : 32'(v);
  endfunction

  task automatic push(input logic [4:0] en, input logic [1:0] s);
    exp_t e;
    e.en = en; e.st = s; e.lu = e_lu; e.fl = e_fl; e.ms = e_ms; e.miss = e_miss;
    sb.push_back(e);
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    e = sb.pop_front();
    chk({tag, ".en"}, 32'({pc_we, ifid_we, flush, bubble, stall}), 32'(e.en));
    chk({tag, ".st"}, 32'(st), 32'(e.st));
    chk({tag, ".lu"}, 32'(lu_cnt), 32'(e.lu));
    chk({tag, ".fl"}, 32'(fl_cnt), 32'(e.fl));
    chk({tag, ".ms"}, 32'(ms_cnt), 32'(e.ms));
    chk({tag, ".miss"}, 32'(miss_cnt), 32'(e.miss));
    chk({tag, ".b_en"}, 32'({b_pc_we, b_ifid_we, b_flush, b_bubble, b_stall}), 32'(e.en));
    chk({tag, ".b_lu"}, 32'(b_lu), sat3(e.lu));
    chk({tag, ".b_fl"}, 32'(b_fl), sat3(e.fl));
    chk({tag, ".b_ms"}, 32'(b_ms), sat3(e.ms));
    chk({tag, ".b_miss"}, 32'(b_miss), sat3(e.miss));
  endtask

  // called just after a negedge with inputs already driven; d = {lu, fl, ms, miss} increments
  task automatic cyc(input string tag, input logic [4:0] en, input logic [1:0] s, input logic [3:0] d);
    push(en, s);
    #2;
    check_out(tag);
    @(posedge clk);
    if (clr) begin
      e_lu = 0; e_fl = 0; e_ms = 0; e_miss = 0;
    end else begin
      e_lu += int'(d[3]); e_fl += int'(d[2]); e_ms += int'(d[1]); e_miss += int'(d[0]);
    end
    @(negedge clk);
  endtask

  task automatic lu_in(input logic m, input logic [4:0] r, input logic [4:0] s);
    memread = m; ex_rt = r; id_rs = s;
  endtask

  localparam logic [4:0] IDLE_EN = 5'b00001, RUN_EN = 5'b11000, BUB_EN = 5'b00010,
                         FL_EN = 5'b11100, FRZ_EN = 5'b00001;

  initial begin
    n_vec = 0; n_err = 0; e_lu = 0; e_fl = 0; e_ms = 0; e_miss = 0;
    rst_n = 0; start = 0; clr = 0; memread = 0; use_rt = 0; br = 0; jmp = 0; dmem = 0;
    ex_rt = 0; id_rs = 0; id_rt = 0;
    push(IDLE_EN, 2'b00);
    #2 check_out("reset");
    @(negedge clk);
    rst_n = 1;
    cyc("idle0", IDLE_EN, 2'b00, 4'b0000);
    cyc("idle1", IDLE_EN, 2'b00, 4'b0000);
    start = 1;
    cyc("start", IDLE_EN, 2'b00, 4'b0000);
    cyc("run", RUN_EN, 2'b01, 4'b0000);
    lu_in(1, 5'd8, 5'd8);
    cyc("lu_rs", BUB_EN, 2'b01, 4'b1000);
    lu_in(0, 5'd8, 5'd8);
    cyc("lu_after", RUN_EN, 2'b01, 4'b0000);
    lu_in(1, 5'd0, 5'd0);
    cyc("lu_r0", RUN_EN, 2'b01, 4'b0000);
    lu_in(1, 5'd5, 5'd3); id_rt = 5'd5; use_rt = 1;
    cyc("lu_rt", BUB_EN, 2'b01, 4'b1000);
    use_rt = 0;
    cyc("lu_rt_unused", RUN_EN, 2'b01, 4'b0000);
    lu_in(1, 5'd8, 5'd8); br = 1;
    cyc("br_lu", BUB_EN, 2'b01, 4'b1000);
    lu_in(0, 5'd0, 5'd0);
    cyc("br", FL_EN, 2'b01, 4'b0100);
    br = 0; jmp = 1;
    cyc("jmp", FL_EN, 2'b01, 4'b0100);
    jmp = 0; br = 1; dmem = 1;
    cyc("miss0", FRZ_EN, 2'b01, 4'b0011);
    cyc("miss1", FRZ_EN, 2'b10, 4'b0010);
    cyc("miss2", FRZ_EN, 2'b10, 4'b0010);
    cyc("miss3", FRZ_EN, 2'b10, 4'b0010);
    dmem = 0;
    cyc("miss_end", FL_EN, 2'b10, 4'b0100);
    br = 0;
    cyc("miss_run", RUN_EN, 2'b01, 4'b0000);
    dmem = 1;
    cyc("drop0", FRZ_EN, 2'b01, 4'b0011);
    start = 0;
    cyc("drop1", FRZ_EN, 2'b10, 4'b0010);
    cyc("drop2", FRZ_EN, 2'b10, 4'b0010);
    dmem = 0;
    cyc("drop_end", RUN_EN, 2'b10, 4'b0000);
    lu_in(1, 5'd8, 5'd8); br = 1; dmem = 1;
    cyc("idle_ev", IDLE_EN, 2'b00, 4'b0000);
    lu_in(0, 5'd0, 5'd0); br = 0; dmem = 0; start = 1;
    cyc("restart", IDLE_EN, 2'b00, 4'b0000);
    start = 0;
    cyc("run_stop", RUN_EN, 2'b01, 4'b0000);
    start = 1;
    cyc("idle_again", IDLE_EN, 2'b00, 4'b0000);
    lu_in(1, 5'd8, 5'd8);
    for (int i = 0; i < 5; i++) cyc("sat_lu", BUB_EN, 2'b01, 4'b1000);
    clr = 1;
    cyc("clr_lu", BUB_EN, 2'b01, 4'b1000);
    clr = 0; lu_in(0, 5'd0, 5'd0);
    cyc("after_clr", RUN_EN, 2'b01, 4'b0000);
    dmem = 1;
    cyc("rmiss0", FRZ_EN, 2'b01, 4'b0011);
    cyc("rmiss1", FRZ_EN, 2'b10, 4'b0010);
    rst_n = 0;
    e_lu = 0; e_fl = 0; e_ms = 0; e_miss = 0;
    push(IDLE_EN, 2'b00);
    #2 check_out("rst_mid_miss");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
